// File: rtl/pr_free_allocator_pkg.sv
// Shared physical-register index types and allocator defaults, also used by the
// register file and the rename table.
package pr_free_allocator_pkg;

  localparam int unsigned DEFAULT_NUM_PHY_REGS   = 64;
  localparam int unsigned DEFAULT_NUM_SICS       = 2;
  localparam int unsigned DEFAULT_FIRST_ALLOC_PR = 32;
  localparam int unsigned DEFAULT_HOLD_CYCLES    = 4;

  localparam int unsigned PR_IDX_W = $clog2(DEFAULT_NUM_PHY_REGS);
  typedef logic [PR_IDX_W-1:0] pr_idx_t;

  // Circular successor inside the allocatable window [first, num).
  function automatic int unsigned pr_wrap_inc(int unsigned idx, int unsigned first,
                                              int unsigned num);
    return (idx + 1 >= num) ? first : idx + 1;
  endfunction

endpackage

// File: rtl/pr_wrap_finder.sv
// Combinational circular first-one search over a mask, starting at a given index.
module pr_wrap_finder #(
  parameter int unsigned NUM_BITS = 64,
  parameter int unsigned IDX_W    = $clog2(NUM_BITS)
) (
  input  logic [NUM_BITS-1:0] mask,
  input  logic [IDX_W-1:0]    start,
  output logic                found,
  output logic [IDX_W-1:0]    idx
);

  always_comb begin
    int unsigned j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int unsigned i = 0; i < NUM_BITS; i++) begin
      j = 32'(start) + i;
      if (j >= NUM_BITS) j = j - NUM_BITS;
      if (!found && mask[j[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pr_free_allocator.sv
// Grants free physical registers to per-SIC requests with rotating SIC priority,
// a rotating scan pointer and a short per-PR hold after each grant.
module pr_free_allocator
  import pr_free_allocator_pkg::*;
#(
  parameter int unsigned NUM_PHY_REGS   = DEFAULT_NUM_PHY_REGS,
  parameter int unsigned NUM_SICS       = DEFAULT_NUM_SICS,
  parameter int unsigned FIRST_ALLOC_PR = DEFAULT_FIRST_ALLOC_PR,
  parameter int unsigned HOLD_CYCLES    = DEFAULT_HOLD_CYCLES
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_SICS-1:0]                          alloc_req,
  input  logic [NUM_PHY_REGS-1:0]                      pr_not_idle,
  input  logic [NUM_PHY_REGS-1:0]                      pr_mapped,
  output logic [NUM_SICS-1:0]                          alloc_wen,
  output logic [NUM_SICS-1:0][$clog2(NUM_PHY_REGS)-1:0] alloc_pr,
  output logic [$clog2(NUM_PHY_REGS):0]                free_count,
  output logic                                         ready
);

  localparam int unsigned IdxW  = $clog2(NUM_PHY_REGS);
  localparam int unsigned CntW  = IdxW + 1;
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned PrioW = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;

  typedef logic [IdxW-1:0] idx_t;

  logic                    ready_q;
  logic [HoldW-1:0]        hold_q [NUM_PHY_REGS];
  logic [HoldW-1:0]        hold_d [NUM_PHY_REGS];
  idx_t                    scan_ptr_q, scan_ptr_d;
  logic [PrioW-1:0]        sic_prio_q, sic_prio_d;
  logic [NUM_PHY_REGS-1:0] cand, granted;

  // stage_mask[k] is the candidate set still available to visit-order stage k.
  logic [NUM_PHY_REGS-1:0] stage_mask [NUM_SICS+1];
  logic [NUM_SICS-1:0]     stage_found, stage_grant;
  idx_t                    stage_idx [NUM_SICS];
  logic [PrioW-1:0]        stage_sic [NUM_SICS];

  always_comb begin
    cand = '0;
    for (int p = 0; p < int'(NUM_PHY_REGS); p++) begin
      cand[p] = ready_q && (p >= int'(FIRST_ALLOC_PR)) && !pr_not_idle[p] && !pr_mapped[p] &&
                (hold_q[p] == '0);
    end
  end

  always_comb begin
    free_count = '0;
    for (int p = 0; p < int'(NUM_PHY_REGS); p++) free_count = free_count + CntW'(cand[p]);
  end

  assign stage_mask[0] = cand;

  for (genvar k = 0; k < int'(NUM_SICS); k++) begin : g_stage
    assign stage_sic[k] = PrioW'((32'(sic_prio_q) + k) % NUM_SICS);

    pr_wrap_finder #(
      .NUM_BITS (NUM_PHY_REGS),
      .IDX_W    (IdxW)
    ) u_finder (
      .mask  (stage_mask[k]),
      .start (scan_ptr_q),
      .found (stage_found[k]),
      .idx   (stage_idx[k])
    );

    assign stage_grant[k]  = alloc_req[stage_sic[k]] && stage_found[k];
    assign stage_mask[k+1] = stage_grant[k] ?
        (stage_mask[k] & ~({{(NUM_PHY_REGS-1){1'b0}}, 1'b1} << stage_idx[k])) : stage_mask[k];
  end

  assign granted = stage_mask[0] & ~stage_mask[NUM_SICS];
  assign ready   = ready_q;

  always_comb begin
    logic first_seen;
    alloc_wen  = '0;
    alloc_pr   = '0;
    scan_ptr_d = scan_ptr_q;
    sic_prio_d = sic_prio_q;
    first_seen = 1'b0;
    for (int k = 0; k < int'(NUM_SICS); k++) begin
      if (stage_grant[k]) begin
        alloc_wen[stage_sic[k]] = 1'b1;
        alloc_pr[stage_sic[k]]  = stage_idx[k];
        scan_ptr_d = idx_t'(pr_wrap_inc(32'(stage_idx[k]), FIRST_ALLOC_PR, NUM_PHY_REGS));
        if (!first_seen) sic_prio_d = PrioW'((32'(stage_sic[k]) + 1) % NUM_SICS);
        first_seen = 1'b1;
      end
    end
  end

  // Any reference or live mapping proves the consumer has the PR, so the hold ends early.
  always_comb begin
    for (int p = 0; p < int'(NUM_PHY_REGS); p++) begin
      hold_d[p] = hold_q[p];
      if (granted[p]) begin
        hold_d[p] = HoldW'(HOLD_CYCLES);
      end else if (hold_q[p] != '0) begin
        hold_d[p] = (pr_not_idle[p] || pr_mapped[p]) ? '0 : hold_q[p] - HoldW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      scan_ptr_q <= idx_t'(FIRST_ALLOC_PR);
      sic_prio_q <= '0;
      for (int p = 0; p < int'(NUM_PHY_REGS); p++) hold_q[p] <= '0;
    end else begin
      ready_q    <= 1'b1;
      scan_ptr_q <= scan_ptr_d;
      sic_prio_q <= sic_prio_d;
      for (int p = 0; p < int'(NUM_PHY_REGS); p++) hold_q[p] <= hold_d[p];
    end
  end

  a_first_pr_legal : assert property (@(posedge clk) FIRST_ALLOC_PR >= 1);

  for (genvar s = 0; s < int'(NUM_SICS); s++) begin : g_chk
    a_pr_in_window : assert property (@(posedge clk) disable iff (!rst_n)
        alloc_wen[s] |-> (32'(alloc_pr[s]) >= FIRST_ALLOC_PR));
    for (genvar t = s + 1; t < int'(NUM_SICS); t++) begin : g_pair
      a_distinct : assert property (@(posedge clk) disable iff (!rst_n)
          !(alloc_wen[s] && alloc_wen[t] && (alloc_pr[s] == alloc_pr[t])));
    end
  end

endmodule

// File: tb/tb_pr_free_allocator.sv
// Directed self-checking bench for pr_free_allocator (64 PRs, 2 SICs, first PR 32, hold 4).
module tb_pr_free_allocator;

  logic            clk;
  logic            rst_n;
  logic [1:0]      alloc_req;
  logic [63:0]     pr_not_idle;
  logic [63:0]     pr_mapped;
  logic [1:0]      alloc_wen;
  logic [1:0][5:0] alloc_pr;
  logic [6:0]      free_count;
  logic            ready;

  int n_cmp;
  int n_fail;

  pr_free_allocator #(
    .NUM_PHY_REGS   (64),
    .NUM_SICS       (2),
    .FIRST_ALLOC_PR (32),
    .HOLD_CYCLES    (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_req   (alloc_req),
    .pr_not_idle (pr_not_idle),
    .pr_mapped   (pr_mapped),
    .alloc_wen   (alloc_wen),
    .alloc_pr    (alloc_pr),
    .free_count  (free_count),
    .ready       (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    tick();
    alloc_req   = 2'b00;
    pr_not_idle = '0;
    pr_mapped   = '0;
    rst_n       = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    alloc_req   = 2'b11;
    pr_not_idle = '0;
    pr_mapped   = '0;
    tick();
    tick();
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", ready); end
    n_cmp++; if (alloc_wen !== 2'b00) begin n_fail++; $display("FAIL rst_wen got %b exp 00", alloc_wen); end
    n_cmp++; if (alloc_pr !== 12'd0) begin n_fail++; $display("FAIL rst_pr got %h exp 000", alloc_pr); end
    n_cmp++; if (free_count !== 7'd0) begin n_fail++; $display("FAIL rst_free got %0d exp 0", free_count); end
    alloc_req = 2'b00;
    rst_n     = 1'b1;
    settle();
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rel_ready_early got %b exp 0", ready); end
    tick();
    alloc_req = 2'b01;
    settle();
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready got %b exp 1", ready); end
    n_cmp++; if (alloc_wen !== 2'b01) begin n_fail++; $display("FAIL t1_wen got %b exp 01", alloc_wen); end
    n_cmp++; if (alloc_pr[0] !== 6'd32) begin n_fail++; $display("FAIL t1_pr0 got %0d exp 32", alloc_pr[0]); end
    n_cmp++; if (alloc_pr[1] !== 6'd0) begin n_fail++; $display("FAIL t1_pr1 got %0d exp 0", alloc_pr[1]); end
    n_cmp++; if (free_count !== 7'd32) begin n_fail++; $display("FAIL t1_free got %0d exp 32", free_count); end
    tick();
    n_cmp++; if (alloc_pr[0] !== 6'd33) begin n_fail++; $display("FAIL t1_next_pr got %0d exp 33", alloc_pr[0]); end
    n_cmp++; if (free_count !== 7'd31) begin n_fail++; $display("FAIL t1_next_free got %0d exp 31", free_count); end
    alloc_req = 2'b00;
  endtask

  task automatic test_two_sics();
    do_reset();
    alloc_req = 2'b11;
    settle();
    n_cmp++; if (alloc_wen !== 2'b11) begin n_fail++; $display("FAIL t2_wen got %b exp 11", alloc_wen); end
    n_cmp++; if (alloc_pr[0] !== 6'd32) begin n_fail++; $display("FAIL t2_pr0 got %0d exp 32", alloc_pr[0]); end
    n_cmp++; if (alloc_pr[1] !== 6'd33) begin n_fail++; $display("FAIL t2_pr1 got %0d exp 33", alloc_pr[1]); end
    tick();
    n_cmp++; if (alloc_wen !== 2'b11) begin n_fail++; $display("FAIL t2b_wen got %b exp 11", alloc_wen); end
    n_cmp++; if (alloc_pr[1] !== 6'd34) begin n_fail++; $display("FAIL t2b_pr1 got %0d exp 34", alloc_pr[1]); end
    n_cmp++; if (alloc_pr[0] !== 6'd35) begin n_fail++; $display("FAIL t2b_pr0 got %0d exp 35", alloc_pr[0]); end
    n_cmp++; if (free_count !== 7'd30) begin n_fail++; $display("FAIL t2b_free got %0d exp 30", free_count); end
    alloc_req = 2'b00;
  endtask

  task automatic test_scarce();
    do_reset();
    pr_mapped = 64'h7FFF_FFFF_0000_0000;
    alloc_req = 2'b11;
    settle();
    n_cmp++; if (alloc_wen !== 2'b01) begin n_fail++; $display("FAIL t3_wen got %b exp 01", alloc_wen); end
    n_cmp++; if (alloc_pr[0] !== 6'd63) begin n_fail++; $display("FAIL t3_pr0 got %0d exp 63", alloc_pr[0]); end
    n_cmp++; if (alloc_pr[1] !== 6'd0) begin n_fail++; $display("FAIL t3_pr1 got %0d exp 0", alloc_pr[1]); end
    n_cmp++; if (free_count !== 7'd1) begin n_fail++; $display("FAIL t3_free got %0d exp 1", free_count); end
    tick();
    n_cmp++; if (free_count !== 7'd0) begin n_fail++; $display("FAIL t3_empty_free got %0d exp 0", free_count); end
    n_cmp++; if (alloc_wen !== 2'b00) begin n_fail++; $display("FAIL t3_empty_wen got %b exp 00", alloc_wen); end
    // Priority is now SIC1 and the scan pointer has wrapped past 63.
    pr_mapped = 64'h8000_0000_0000_0000;
    settle();
    n_cmp++; if (alloc_wen !== 2'b11) begin n_fail++; $display("FAIL t3_wrap_wen got %b exp 11", alloc_wen); end
    n_cmp++; if (alloc_pr[1] !== 6'd32) begin n_fail++; $display("FAIL t3_wrap_pr1 got %0d exp 32", alloc_pr[1]); end
    n_cmp++; if (alloc_pr[0] !== 6'd33) begin n_fail++; $display("FAIL t3_wrap_pr0 got %0d exp 33", alloc_pr[0]); end
    alloc_req = 2'b00;
    pr_mapped = '0;
  endtask

  task automatic test_hold_expire();
    do_reset();
    pr_mapped = ~(64'd1 << 40);
    alloc_req = 2'b01;
    settle();
    n_cmp++; if (alloc_pr[0] !== 6'd40) begin n_fail++; $display("FAIL t4_pr0 got %0d exp 40", alloc_pr[0]); end
    tick();
    alloc_req = 2'b00;
    for (int c = 0; c < 4; c++) begin
      settle();
      n_cmp++;
      if (free_count !== 7'd0) begin
        n_fail++; $display("FAIL t4_held_c%0d got %0d exp 0", c, free_count);
      end
      tick();
    end
    n_cmp++; if (free_count !== 7'd1) begin n_fail++; $display("FAIL t4_expired_free got %0d exp 1", free_count); end
    alloc_req = 2'b01;
    settle();
    n_cmp++; if (alloc_wen !== 2'b01) begin n_fail++; $display("FAIL t4_regrant_wen got %b exp 01", alloc_wen); end
    n_cmp++; if (alloc_pr[0] !== 6'd40) begin n_fail++; $display("FAIL t4_regrant_pr got %0d exp 40", alloc_pr[0]); end
    alloc_req = 2'b00;
    pr_mapped = '0;
  endtask

  task automatic test_hold_clear();
    do_reset();
    pr_mapped = ~(64'd1 << 40);
    alloc_req = 2'b01;
    settle();
    n_cmp++; if (alloc_pr[0] !== 6'd40) begin n_fail++; $display("FAIL t5_pr0 got %0d exp 40", alloc_pr[0]); end
    tick();
    alloc_req       = 2'b00;
    pr_not_idle[40] = 1'b1;
    settle();
    n_cmp++; if (free_count !== 7'd0) begin n_fail++; $display("FAIL t5_ref_free got %0d exp 0", free_count); end
    tick();
    pr_not_idle[40] = 1'b0;
    alloc_req       = 2'b01;
    settle();
    n_cmp++; if (free_count !== 7'd1) begin n_fail++; $display("FAIL t5_clear_free got %0d exp 1", free_count); end
    n_cmp++; if (alloc_wen !== 2'b01) begin n_fail++; $display("FAIL t5_clear_wen got %b exp 01", alloc_wen); end
    n_cmp++; if (alloc_pr[0] !== 6'd40) begin n_fail++; $display("FAIL t5_clear_pr got %0d exp 40", alloc_pr[0]); end
    alloc_req = 2'b00;
    pr_mapped = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_req = 2'b11;
    tick();
    tick();
    n_cmp++; if (alloc_wen !== 2'b11) begin n_fail++; $display("FAIL t6_pre_wen got %b exp 11", alloc_wen); end
    rst_n = 1'b0;
    settle();
    n_cmp++; if (alloc_wen !== 2'b00) begin n_fail++; $display("FAIL t6_mid_wen got %b exp 00", alloc_wen); end
    n_cmp++; if (alloc_pr !== 12'd0) begin n_fail++; $display("FAIL t6_mid_pr got %h exp 000", alloc_pr); end
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL t6_mid_ready got %b exp 0", ready); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    alloc_req = 2'b01;
    settle();
    n_cmp++; if (alloc_wen !== 2'b01) begin n_fail++; $display("FAIL t6_post_wen got %b exp 01", alloc_wen); end
    n_cmp++; if (alloc_pr[0] !== 6'd32) begin n_fail++; $display("FAIL t6_post_pr got %0d exp 32", alloc_pr[0]); end
    alloc_req = 2'b00;
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    alloc_req   = 2'b00;
    pr_not_idle = '0;
    pr_mapped   = '0;
    test_reset();
    test_two_sics();
    test_scarce();
    test_hold_expire();
    test_hold_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
